irq_sequencer: RTL and testbench

//  Interrupt sequencer for the pipelined MIPS core. Latches peripheral interrupt edges,

---
 rtl/irq_sequencer.sv | 162 ++++++++++++++++
 tb/tb_irq_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irq_sequencer
// Description : Interrupt sequencer for the pipelined MIPS core. Captures
//               rising edges on peripheral interrupt lines into a pending
//               register, applies mask and global enable, and delivers a
//               one-cycle IRQ pulse to the ID-stage control unit only at a
//               safe point. It holds off further delivery until the handler
//               has run, meaning kernel mode was entered and then left.
// Ports       : clk          core clock
//               reset        asynchronous active-low reset
//               src_irq      peripheral interrupt lines (rising edge = request)
//               id_valid     ID stage holds a real instruction
//               id_stall     ID stage stalled this cycle
//               id_in_slot   ID instruction is in a branch/jump delay slot
//               kernel_mode  PC[31] of the ID-stage instruction
//               reg_wr       register window write strobe
//               reg_addr     0=mask 1=pending(W1C) 2=cause(RO) 3=enable
//               reg_wdata    register window write data
//               reg_rdata    register window read data (combinational)
//               IRQ          one-cycle interrupt request pulse
//               in_service   high from delivery until handler exit
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            id_valid,
  input  logic            id_stall,
  input  logic            id_in_slot,
  input  logic            kernel_mode,
  input  logic            reg_wr,
  input  logic [1:0]      reg_addr,
  input  logic [31:0]     reg_wdata,
  output logic [31:0]     reg_rdata,
  output logic            IRQ,
  output logic            in_service
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_ISSUE   = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  state_t          state;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic            enable;
  logic [2:0]      cause;
  logic            seen_k;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] active;
  logic            any;
  logic            safe;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] lo_oh;
  logic [2:0]      lo_idx;
  logic            lo_hit;
  logic [NSRC-1:0] issue_clr;
  logic [NSRC-1:0] pending_nxt;
  logic            unused_wdata;

  assign unused_wdata = ^reg_wdata;

  assign rise   = src_irq & ~src_q;
  assign active = pending & mask;
  assign any    = (|active) & enable;
  assign safe   = id_valid & ~id_stall & ~id_in_slot & ~kernel_mode;
  assign w1c    = (reg_wr && reg_addr == 2'd1) ? reg_wdata[NSRC-1:0] : '0;

  // Lowest-index active source, both as an index (for cause) and one-hot
  // (for clearing the pending bit being delivered).
  always_comb begin
    lo_oh  = '0;
    lo_idx = 3'd0;
    lo_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (active[i] && !lo_hit) begin
        lo_hit   = 1'b1;
        lo_idx   = 3'(i);
        lo_oh[i] = 1'b1;
      end
    end
  end

  assign issue_clr = (state == S_ISSUE) ? lo_oh : '0;

  // New edges are OR-ed in last so a source that re-rises in the same cycle
  // as a software or delivery clear stays pending.
  assign pending_nxt = (pending & ~w1c & ~issue_clr) | rise;

  always_comb begin
    reg_rdata = 32'd0;
    case (reg_addr)
      2'd0:    reg_rdata = 32'(mask);
      2'd1:    reg_rdata = 32'(pending);
      2'd2:    reg_rdata = {29'd0, cause};
      default: reg_rdata = {31'd0, enable};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      src_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      enable     <= 1'b0;
      cause      <= 3'd0;
      seen_k     <= 1'b0;
      IRQ        <= 1'b0;
      in_service <= 1'b0;
    end else begin
      src_q   <= src_irq;
      pending <= pending_nxt;
      if (reg_wr && reg_addr == 2'd0) mask   <= reg_wdata[NSRC-1:0];
      if (reg_wr && reg_addr == 2'd3) enable <= reg_wdata[0];

      case (state)
        S_IDLE: begin
          if (any && !kernel_mode) state <= S_ARM;
        end
        S_ARM: begin
          // Losing the request (mask/clear/disable) takes priority over issuing.
          if (!any) begin
            state <= S_IDLE;
          end else if (safe) begin
            state <= S_ISSUE;
            IRQ   <= 1'b1;
          end
        end
        S_ISSUE: begin
          IRQ        <= 1'b0;
          if (lo_hit) cause <= lo_idx;
          in_service <= 1'b1;
          seen_k     <= 1'b0;
          state      <= S_SERVICE;
        end
        default: begin
          // Handler is considered finished on the first user-mode cycle
          // after at least one kernel-mode cycle.
          if (kernel_mode) begin
            seen_k <= 1'b1;
          end else if (seen_k) begin
            seen_k     <= 1'b0;
            in_service <= 1'b0;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_sequencer
// Description : Directed self-checking bench for irq_sequencer. Each task
//               drives one scenario and compares outputs against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

  localparam int NSRC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src_irq;
  logic            id_valid;
  logic            id_stall;
  logic            id_in_slot;
  logic            kernel_mode;
  logic            reg_wr;
  logic [1:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            IRQ;
  logic            in_service;

  int total = 0;
  int bad   = 0;

  irq_sequencer #(.NSRC(NSRC)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_irq     (src_irq),
    .id_valid    (id_valid),
    .id_stall    (id_stall),
    .id_in_slot  (id_in_slot),
    .kernel_mode (kernel_mode),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .IRQ         (IRQ),
    .in_service  (in_service)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_wr    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    step(1);
    reg_wr    = 1'b0;
    reg_wdata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    src_irq     = '0;
    id_valid    = 1'b0;
    id_stall    = 1'b0;
    id_in_slot  = 1'b0;
    kernel_mode = 1'b0;
    reg_wr      = 1'b0;
    reg_addr    = 2'd0;
    reg_wdata   = 32'd0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq: got %0b want 0", IRQ); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL reset_insvc: got %0b want 0", in_service); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_reg%0d: got %0h want 0", a, d); end
    end
    // Reset asserted while ARM with pending=0010.
    wr(2'd0, 32'hF);
    wr(2'd3, 32'h1);
    src_irq = 4'b0010;
    step(2);
    rd(2'd1, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL arm_pending: got %0h want 2", d); end
    reset   = 1'b0;
    src_irq = '0;
    #2;
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL midarm_irq: got %0b want 0", IRQ); end
    rd(2'd0, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL midarm_mask: got %0h want 0", d); end
    rd(2'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL midarm_pending: got %0h want 0", d); end
    rd(2'd3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL midarm_enable: got %0h want 0", d); end
    step(1);
    reset = 1'b1;
    // Enabled again with nothing pending and pipeline safe: no IRQ may appear.
    id_valid = 1'b1;
    wr(2'd0, 32'hF);
    wr(2'd3, 32'h1);
    for (int c = 0; c < 4; c++) begin
      step(1);
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL post_reset_idle c%0d: got %0b want 0", c, IRQ); end
    end
    // Reset asserted during the ISSUE cycle.
    src_irq = 4'b0001;
    step(3);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL pre_issue_irq: got %0b want 1", IRQ); end
    reset = 1'b0;
    #2;
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL midissue_irq: got %0b want 0", IRQ); end
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL midissue_insvc: got %0b want 0", in_service); end
    src_irq = '0;
    step(1);
    reset = 1'b1;
  endtask

  task automatic test_latency();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'hF);
    wr(2'd3, 32'h1);
    id_valid = 1'b1;
    src_irq  = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      src_irq = '0;
      total++;
      if (IRQ !== (c == 3)) begin bad++; $display("FAIL latency_c%0d: got %0b want %0b", c, IRQ, (c == 3)); end
    end
    rd(2'd2, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL latency_cause: got %0h want 2", d); end
    rd(2'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL latency_pending: got %0h want 0", d); end
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL latency_insvc: got %0b want 1", in_service); end
    kernel_mode = 1'b1;
    step(2);
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL handler_insvc: got %0b want 1", in_service); end
    kernel_mode = 1'b0;
    step(1);
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL exit_insvc: got %0b want 0", in_service); end
    for (int c = 0; c < 3; c++) begin
      step(1);
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL after_exit c%0d: got %0b want 0", c, IRQ); end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    int          pulses;
    do_reset();
    wr(2'd0, 32'hF);
    wr(2'd3, 32'h1);
    id_valid = 1'b1;
    src_irq  = 4'b1010;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      src_irq = '0;
      total++;
      if (IRQ !== (c == 3)) begin bad++; $display("FAIL simul_first_c%0d: got %0b want %0b", c, IRQ, (c == 3)); end
    end
    rd(2'd2, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL simul_cause1: got %0h want 1", d); end
    rd(2'd1, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL simul_pending1: got %0h want 8", d); end
    // No second pulse while the handler is still running.
    pulses = 0;
    id_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      kernel_mode = (c > 0);
      step(1);
      if (IRQ === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL simul_in_handler: got %0d pulses want 0", pulses); end
    kernel_mode = 1'b0;
    step(1);
    total++; if (in_service !== 1'b0) begin bad++; $display("FAIL simul_exit: got %0b want 0", in_service); end
    step(1);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL simul_arm: got %0b want 0", IRQ); end
    step(1);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL simul_second: got %0b want 1", IRQ); end
    step(1);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL simul_pulse_width: got %0b want 0", IRQ); end
    rd(2'd2, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL simul_cause2: got %0h want 3", d); end
    rd(2'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL simul_pending2: got %0h want 0", d); end
  endtask

  task automatic test_delay_slot();
    logic [31:0] d;
    do_reset();
    wr(2'd0, 32'hF);
    wr(2'd3, 32'h1);
    id_valid   = 1'b1;
    id_in_slot = 1'b1;
    src_irq    = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      step(1);
      src_irq = '0;
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL slot_hold_c%0d: got %0b want 0", c, IRQ); end
    end
    id_in_slot = 1'b0;
    step(1);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL slot_release: got %0b want 1", IRQ); end
    step(1);
    rd(2'd2, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL slot_cause: got %0h want 0", d); end
  endtask

  task automatic test_mask_in_arm();
    logic [31:0] d;
    int          pulses;
    do_reset();
    wr(2'd0, 32'hF);
    wr(2'd3, 32'h1);
    src_irq = 4'b0010;
    step(1);
    src_irq = '0;
    step(1);
    wr(2'd0, 32'hD);
    id_valid = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (IRQ === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL masked_arm: got %0d pulses want 0", pulses); end
    rd(2'd1, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL masked_pending: got %0h want 2", d); end
    rd(2'd0, d);
    total++; if (d !== 32'hD) begin bad++; $display("FAIL masked_mask: got %0h want d", d); end
    // Disable while in ARM: back to IDLE, no pulse; re-enable delivers.
    id_valid = 1'b0;
    wr(2'd0, 32'hF);
    step(1);
    wr(2'd3, 32'h0);
    id_valid = 1'b1;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (IRQ === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL disabled_arm: got %0d pulses want 0", pulses); end
    wr(2'd3, 32'h1);
    step(1);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reenable_arm: got %0b want 0", IRQ); end
    step(1);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL reenable_issue: got %0b want 1", IRQ); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    do_reset();
    src_irq   = 4'b0001;
    reg_wr    = 1'b1;
    reg_addr  = 2'd1;
    reg_wdata = 32'h1;
    step(1);
    reg_wr    = 1'b0;
    reg_wdata = 32'd0;
    rd(2'd1, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL w1c_set_wins: got %0h want 1", d); end
    src_irq = 4'b0101;
    step(1);
    rd(2'd1, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL w1c_second_rise: got %0h want 5", d); end
    wr(2'd1, 32'h1);
    rd(2'd1, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL w1c_clear: got %0h want 4", d); end
    wr(2'd2, 32'h7);
    rd(2'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cause_readonly: got %0h want 0", d); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL w1c_masked_irq: got %0b want 0", IRQ); end
    src_irq = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_simultaneous();
    test_delay_slot();
    test_mask_in_arm();
    test_w1c();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
